// File: rtl/arith_loop_gen.sv
// arith_loop_gen: two-state (RUN/DONE) loop-index generator with counters i/j,
// a step counter that stops the loop at LIMIT, and a registered i+j sum.
// Optional feature macro: SATURATE_EN (clamp counters at 2^W-1 and raise
// sticky sat instead of wrapping modulo 2^W).
module arith_loop_gen #(
    parameter int unsigned W      = 15,
    parameter int unsigned STEP_I = 1,
    parameter int unsigned STEP_J = 1,
    parameter int unsigned LIMIT  = (1 << W) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         selector,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic [W:0]   sum,
    output logic [W-1:0] steps,
    output logic         done,
    output logic         sat
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0] ONE_V   = W'(1);

`ifdef SATURATE_EN
    localparam logic [W:0]   STEP_I_V = (W+1)'(STEP_I);
    localparam logic [W:0]   STEP_J_V = (W+1)'(STEP_J);
    localparam logic [W-1:0] MAX_V    = {W{1'b1}};
    logic [W:0]   inc_i;
    logic [W:0]   inc_j;
`else
    localparam logic [W-1:0] STEP_I_V = W'(STEP_I);
    localparam logic [W-1:0] STEP_J_V = W'(STEP_J);
    logic [W-1:0] inc_i;
    logic [W-1:0] inc_j;
`endif

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] i_nxt;
    logic [W-1:0] j_nxt;
    logic [W:0]   sum_nxt;
    logic [W-1:0] steps_nxt;
    logic         done_nxt;
    logic         sat_nxt;

    // Next-state and datapath: accept a step in RUN when en is high
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        steps_nxt = steps;
        sat_nxt   = sat;
        sum_nxt   = {1'b0, i} + {1'b0, j};
`ifdef SATURATE_EN
        inc_i     = {1'b0, i} + STEP_I_V;
        inc_j     = {1'b0, j} + STEP_J_V;
`else
        inc_i     = i + STEP_I_V;
        inc_j     = j + STEP_J_V;
`endif
        case (state)
            ST_RUN: begin
                if (en) begin
                    steps_nxt = steps + ONE_V;
`ifdef SATURATE_EN
                    if (selector) begin
                        if (inc_i[W]) begin
                            i_nxt   = MAX_V;
                            sat_nxt = 1'b1;
                        end else begin
                            i_nxt = inc_i[W-1:0];
                        end
                    end else begin
                        if (inc_j[W]) begin
                            j_nxt   = MAX_V;
                            sat_nxt = 1'b1;
                        end else begin
                            j_nxt = inc_j[W-1:0];
                        end
                    end
`else
                    if (selector) begin
                        i_nxt = inc_i;
                    end else begin
                        j_nxt = inc_j;
                    end
`endif
                    if (steps_nxt == LIMIT_V) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        done_nxt = (state_nxt == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            i     <= '0;
            j     <= '0;
            sum   <= '0;
            steps <= '0;
            done  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            sum   <= sum_nxt;
            steps <= steps_nxt;
            done  <= done_nxt;
            sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_arith_loop_gen.sv
// Bench for arith_loop_gen: three parameterisations driven by common stimulus,
// an arithmetic reference model per instance, and directed literal checks.
module tb_arith_loop_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic [14:0] ia, ja, stepsa;
    logic [15:0] suma;
    logic        donea, sata;
    // Instance B: W=4, STEP_I=3, LIMIT=15
    logic [3:0]  ib, jb, stepsb;
    logic [4:0]  sumb;
    logic        doneb, satb;
    // Instance C: LIMIT=8
    logic [14:0] ic, jc, stepsc;
    logic [15:0] sumc;
    logic        donec, satc;

    arith_loop_gen dut_a (
        .clk(clk), .rst(rst), .en(en), .selector(sel),
        .i(ia), .j(ja), .sum(suma), .steps(stepsa), .done(donea), .sat(sata)
    );

    arith_loop_gen #(.W(4), .STEP_I(3), .STEP_J(1), .LIMIT(15)) dut_b (
        .clk(clk), .rst(rst), .en(en), .selector(sel),
        .i(ib), .j(jb), .sum(sumb), .steps(stepsb), .done(doneb), .sat(satb)
    );

    arith_loop_gen #(.W(15), .STEP_I(1), .STEP_J(1), .LIMIT(8)) dut_c (
        .clk(clk), .rst(rst), .en(en), .selector(sel),
        .i(ic), .j(jc), .sum(sumc), .steps(stepsc), .done(donec), .sat(satc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-instance configuration and state
    longint cw[3]  = '{15, 4, 15};
    longint csi[3] = '{1, 3, 1};
    longint csj[3] = '{1, 1, 1};
    longint clim[3] = '{32767, 15, 8};
    longint mi[3], mj[3], msum[3], mst[3];
    bit     mdone[3], msat[3];
    bit     armed = 1'b0;

    // Model update on each rising edge from the behavioural rules
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mi[k] = 0; mj[k] = 0; msum[k] = 0; mst[k] = 0;
                mdone[k] = 0; msat[k] = 0;
            end else begin
                longint cap, t;
                cap = (longint'(1) << cw[k]) - 1;
                msum[k] = mi[k] + mj[k];
                if (!mdone[k] && en) begin
                    t = sel ? mi[k] + csi[k] : mj[k] + csj[k];
`ifdef SATURATE_EN
                    if (t > cap) begin
                        t = cap;
                        msat[k] = 1;
                    end
`else
                    t = t % (cap + 1);
`endif
                    if (sel) mi[k] = t; else mj[k] = t;
                    mst[k] = mst[k] + 1;
                    if (mst[k] == clim[k]) mdone[k] = 1;
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (armed) begin
            chk("a_i", 64'(ia), mi[0]);     chk("a_j", 64'(ja), mj[0]);
            chk("a_sum", 64'(suma), msum[0]); chk("a_steps", 64'(stepsa), mst[0]);
            chk("a_done", 64'(donea), 64'(mdone[0])); chk("a_sat", 64'(sata), 64'(msat[0]));
            chk("b_i", 64'(ib), mi[1]);     chk("b_j", 64'(jb), mj[1]);
            chk("b_sum", 64'(sumb), msum[1]); chk("b_steps", 64'(stepsb), mst[1]);
            chk("b_done", 64'(doneb), 64'(mdone[1])); chk("b_sat", 64'(satb), 64'(msat[1]));
            chk("c_i", 64'(ic), mi[2]);     chk("c_j", 64'(jc), mj[2]);
            chk("c_sum", 64'(sumc), msum[2]); chk("c_steps", 64'(stepsc), mst[2]);
            chk("c_done", 64'(donec), 64'(mdone[2])); chk("c_sat", 64'(satc), 64'(msat[2]));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic s, input int n);
        for (int c = 0; c < n; c++) begin
            rst = r; en = e; sel = s;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 2);
        chk("rst_i", 64'(ia), 0);     chk("rst_j", 64'(ja), 0);
        chk("rst_sum", 64'(suma), 0); chk("rst_steps", 64'(stepsa), 0);
        chk("rst_done", 64'(donea), 0); chk("rst_sat", 64'(sata), 0);

        // Five i-steps, then sum follows one cycle later
        cyc(1'b0, 1'b1, 1'b1, 5);
        chk("r030_i", 64'(ia), 5); chk("r030_j", 64'(ja), 0);
        chk("r030_steps", 64'(stepsa), 5);
        cyc(1'b0, 1'b0, 1'b0, 1);
        chk("r030_sum", 64'(suma), 5);

        // Wrap or saturate on the narrow instance
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b1, 6);
`ifdef SATURATE_EN
        chk("r032_i", 64'(ib), 15); chk("r032_sat", 64'(satb), 1);
`else
        chk("r032_i", 64'(ib), 2);  chk("r032_sat", 64'(satb), 0);
`endif
        chk("r032_steps", 64'(stepsb), 6);

        // Alternating selector
        cyc(1'b1, 1'b0, 1'b0, 1);
        for (int n = 0; n < 10; n++) cyc(1'b0, 1'b1, (n % 2 == 0), 1);
        cyc(1'b0, 1'b0, 1'b0, 1);
        chk("r031_i", 64'(ia), 5); chk("r031_j", 64'(ja), 5);
        chk("r031_steps", 64'(stepsa), 10); chk("r031_sum", 64'(suma), 10);
        chk("r031_c_i", 64'(ic), 4); chk("r031_c_j", 64'(jc), 4);
        chk("r031_c_done", 64'(donec), 1);

        // LIMIT reached: done timing and hold in DONE
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b1, 7);
        chk("r033_done7", 64'(donec), 0);
        cyc(1'b0, 1'b1, 1'b1, 1);
        chk("r033_done8", 64'(donec), 1); chk("r033_steps8", 64'(stepsc), 8);
        cyc(1'b0, 1'b1, 1'b0, 4);
        chk("r033_i", 64'(ic), 8); chk("r033_j", 64'(jc), 0);
        chk("r033_steps", 64'(stepsc), 8); chk("r033_done", 64'(donec), 1);

        // en low freezes everything
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b1, 3);
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 1'b0, 1'b1, 1);
            chk("r034_i", 64'(ia), 3); chk("r034_steps", 64'(stepsa), 3);
            chk("r034_sum", 64'(suma), 3);
        end
        cyc(1'b0, 1'b1, 1'b0, 1);
        chk("r034_resume_j", 64'(ja), 1); chk("r034_resume_steps", 64'(stepsa), 4);

        // Reset wins over en mid-run and over DONE
        cyc(1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b1, 1'b1, 7);
        cyc(1'b0, 1'b1, 1'b0, 4);
        chk("r035_pre_i", 64'(ia), 7); chk("r035_pre_j", 64'(ja), 4);
        cyc(1'b1, 1'b1, 1'b1, 1);
        chk("r035_i", 64'(ia), 0); chk("r035_j", 64'(ja), 0);
        chk("r035_sum", 64'(suma), 0); chk("r035_steps", 64'(stepsa), 0);
        chk("r035_done_c", 64'(donec), 0); chk("r035_steps_c", 64'(stepsc), 0);
        cyc(1'b0, 1'b1, 1'b1, 1);
        chk("r035_steps1", 64'(stepsa), 1); chk("r035_i1", 64'(ia), 1);

        cyc(1'b0, 1'b0, 1'b0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_loop_gen.md
ARITH_LOOP_GEN -- requirements
Module: arith_loop_gen

Interface
REQ-001 Parameter W, default 15, width of counters i, j and step counter steps.
REQ-002 Parameter STEP_I, default 1, increment applied to i on a selected step.
REQ-003 Parameter STEP_J, default 1, increment applied to j on a selected step.
REQ-004 Parameter LIMIT, default 2^W-1, number of accepted steps before completion; legal range 1..2^W-1.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  step enable; a step is accepted on a rising edge with en=1 in RUN.
REQ-008 selector  input  1  1 = update i, 0 = update j for the accepted step.
REQ-009 i  output  W  counter i, registered.
REQ-010 j  output  W  counter j, registered.
REQ-011 sum  output  W+1  registered i+j, full width, no truncation.
REQ-012 steps  output  W  count of accepted steps, registered.
REQ-013 done  output  1  high while in DONE state.
REQ-014 sat  output  1  sticky saturation flag (see Configuration).

Function
REQ-015 The block SHALL implement a two-state FSM: RUN and DONE.
REQ-016 In RUN with en=1, selector=1, i SHALL become i+STEP_I on that edge; j unchanged.
REQ-017 In RUN with en=1, selector=0, j SHALL become j+STEP_J on that edge; i unchanged.
REQ-018 Every accepted step SHALL increment steps by exactly 1.
REQ-019 In RUN with en=0, i, j, steps SHALL hold.
REQ-020 When an accepted step makes steps equal LIMIT, the FSM SHALL enter DONE on that same edge; done reads 1 from the following cycle.
REQ-021 In DONE, i, j, steps SHALL hold regardless of en/selector; only rst exits DONE.
REQ-022 sum SHALL equal i+j of the previous cycle (one-cycle latency), zero-extended operands, W+1-bit result.
REQ-023 Counter increments SHALL be computed modulo 2^W (wrap) unless SATURATE_EN is defined.
REQ-024 STEP_I/STEP_J values of 0 SHALL be legal; the step still counts toward LIMIT.

Reset
REQ-025 rst=1 at a rising edge SHALL set i=0, j=0, sum=0, steps=0, done=0, sat=0, state RUN.
REQ-026 rst SHALL take priority over en, selector and DONE on the same edge.
REQ-027 Reset mid-run SHALL discard all accumulated state; no partial step is retained.

Configuration
REQ-028 Macro SATURATE_EN: when defined, an increment that would exceed 2^W-1 SHALL clamp the counter at 2^W-1 and set sat=1 (sticky until rst); the step still counts.
REQ-029 Without SATURATE_EN, counters SHALL wrap modulo 2^W and sat SHALL be constant 0.

Verification
REQ-030 Defaults; rst 2 cycles, then en=1, selector=1 for 5 edges -> i=5, j=0, steps=5; sum=5 one cycle after i reaches 5.
REQ-031 Defaults; en=1, selector alternating 1,0 for 10 edges -> i=5, j=5, steps=10, sum=10 next cycle.
REQ-032 W=4, STEP_I=3, LIMIT=15; selector=1, en=1 for 6 edges -> no macro: i=2 (18 mod 16), sat=0; with SATURATE_EN: i=15, sat=1.
REQ-033 LIMIT=8; en=1 for 12 edges -> steps=8, done=1 from cycle after 8th step, i/j/steps unchanged by edges 9-12.
REQ-034 en toggled 0 for 3 cycles mid-run -> i, j, steps, sum frozen during those cycles.
REQ-035 rst=1 with en=1 after i=7, j=4 -> next edge all outputs 0, state RUN; next en=1 step gives steps=1.
